bcd_scan_ctrl: RTL and testbench

- Time-multiplexed scan controller for the BCD-to-decimal decoder.
- Holds a packed multi-digit BCD word and presents one digit at a time on the decoder's 4-bit input (A3..A0).
- For each digit it drives a one-hot digit select, with an inter-digit blanking gap to prevent ghosting.
- Accepts new display values through a valid/ready load handshake; a new value is applied only at frame boundaries, so a frame never shows mixed digits.

---
 rtl/bcd_pkg.sv | 17 +
 rtl/bcd_dwell_timer.sv | 30 +++
 rtl/bcd_scan_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_bcd_scan_ctrl.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared types and helpers for the BCD scan controller.
// Holds the scan state encoding and the BCD digit validity check.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BLANK,
    ST_SHOW
  } scan_state_t;

  localparam logic [3:0] BCD_MAX = 4'd9;

  function automatic logic is_bcd(input logic [3:0] nibble);
    return (nibble <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_dwell_timer.sv
// Loadable down-counter shared by the blank and show phases.
// tc is high while the count sits at zero, i.e. on the last cycle of a phase.
module bcd_dwell_timer #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          tc
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign tc = (count == '0);

endmodule

// File: rtl/bcd_scan_ctrl.sv
// Time-multiplexed scan controller driving one BCD digit at a time into the
// decoder, with blanking gaps between digits and frame-aligned value loads.
module bcd_scan_ctrl
  import bcd_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DWELL        = 1000,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic [4*NUM_DIGITS-1:0] load_bcd,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_sel,
  output logic                    blank,
  output logic                    digit_err,
  output logic                    frame_done
);

  localparam int unsigned CNT_MAX = (DWELL > BLANK_CYCLES) ? DWELL : BLANK_CYCLES;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);
  localparam int unsigned IW      = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] DWELL_VAL = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_VAL = CW'(BLANK_CYCLES - 1);
  localparam logic [IW-1:0] LAST_IDX  = IW'(NUM_DIGITS - 1);

  scan_state_t             state;
  logic [IW-1:0]           idx;
  logic [4*NUM_DIGITS-1:0] active;
  logic [4*NUM_DIGITS-1:0] shadow;
  logic                    pending;
  logic                    loaded;

  logic          tmr_clr;
  logic          tmr_load;
  logic [CW-1:0] tmr_val;
  logic          tmr_tc;

  logic          take;
  logic          last_digit;
  logic          frame_start;
  logic [3:0]    cur_nib;

  assign load_ready = ~pending;
  assign take       = load_valid & ~pending;
  assign last_digit = (idx == LAST_IDX);

  // Frame starts are where the shadow word may be promoted to active.
  assign frame_start = enable &
                       (((state == ST_IDLE) & (loaded | pending)) |
                        ((state == ST_SHOW) & tmr_tc & last_digit));

  always_comb begin
    cur_nib = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IW'(i)) begin
        cur_nib = active[4*i +: 4];
      end
    end
  end

  always_comb begin
    tmr_clr  = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    if (!enable) begin
      tmr_clr = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (frame_start) begin
            tmr_load = 1'b1;
            tmr_val  = BLANK_VAL;
          end else begin
            tmr_clr = 1'b1;
          end
        end
        ST_BLANK: begin
          if (tmr_tc) begin
            tmr_load = 1'b1;
            tmr_val  = DWELL_VAL;
          end
        end
        ST_SHOW: begin
          if (tmr_tc) begin
            tmr_load = 1'b1;
            tmr_val  = BLANK_VAL;
          end
        end
        default: tmr_clr = 1'b1;
      endcase
    end
  end

  bcd_dwell_timer #(
    .CW(CW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tmr_clr),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tc       (tmr_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      active     <= '0;
      shadow     <= '0;
      pending    <= 1'b0;
      loaded     <= 1'b0;
      bcd_out    <= '0;
      digit_sel  <= '0;
      blank      <= 1'b1;
      digit_err  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;

      // take needs ~pending, so it never collides with a promotion.
      if (take) begin
        shadow  <= load_bcd;
        pending <= 1'b1;
      end
      if (frame_start && pending) begin
        active  <= shadow;
        pending <= 1'b0;
        loaded  <= 1'b1;
      end

      if (!enable) begin
        state     <= ST_IDLE;
        idx       <= '0;
        bcd_out   <= '0;
        digit_sel <= '0;
        blank     <= 1'b1;
        digit_err <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (frame_start) begin
              state <= ST_BLANK;
              idx   <= '0;
            end
          end
          ST_BLANK: begin
            if (tmr_tc) begin
              state <= ST_SHOW;
              if (is_bcd(cur_nib)) begin
                bcd_out   <= cur_nib;
                digit_sel <= NUM_DIGITS'(1) << idx;
                blank     <= 1'b0;
                digit_err <= 1'b0;
              end else begin
                bcd_out   <= '0;
                digit_sel <= '0;
                blank     <= 1'b1;
                digit_err <= 1'b1;
              end
            end
          end
          ST_SHOW: begin
            if (tmr_tc) begin
              state     <= ST_BLANK;
              digit_sel <= '0;
              blank     <= 1'b1;
              digit_err <= 1'b0;
              if (last_digit) begin
                idx        <= '0;
                frame_done <= 1'b1;
              end else begin
                idx <= idx + 1'b1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bcd_scan_ctrl.sv
// Directed bench for bcd_scan_ctrl with NUM_DIGITS=4, DWELL=4, BLANK_CYCLES=1.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_bcd_scan_ctrl;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_bcd;
  logic [3:0]  bcd_out;
  logic [3:0]  digit_sel;
  logic        blank;
  logic        digit_err;
  logic        frame_done;

  int unsigned n_tests;
  int unsigned n_fail;

  bcd_scan_ctrl #(
    .NUM_DIGITS   (4),
    .DWELL        (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_bcd   (load_bcd),
    .bcd_out    (bcd_out),
    .digit_sel  (digit_sel),
    .blank      (blank),
    .digit_err  (digit_err),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // One digit slot: a single blank cycle followed by four show cycles.
  task automatic slot(input logic [15:0] w, input int d, input logic fd,
                      input logic rdy_en, input logic exp_rdy);
    logic [3:0] nib;
    logic [3:0] one;
    one = 4'b0001;
    nib = w[d*4 +: 4];
    check_val($sformatf("d%0d_gap_blank", d), 32'(blank), 32'(1));
    check_val($sformatf("d%0d_gap_sel", d), 32'(digit_sel), 32'(0));
    check_val($sformatf("d%0d_gap_fd", d), 32'(frame_done), 32'(fd));
    if (rdy_en) check_val($sformatf("d%0d_gap_rdy", d), 32'(load_ready), 32'(exp_rdy));
    step();
    for (int c = 0; c < 4; c++) begin
      if (nib <= 4'd9) begin
        check_val($sformatf("d%0d_bcd", d), 32'(bcd_out), 32'(nib));
        check_val($sformatf("d%0d_sel", d), 32'(digit_sel), 32'(one << d));
        check_val($sformatf("d%0d_blank", d), 32'(blank), 32'(0));
        check_val($sformatf("d%0d_err", d), 32'(digit_err), 32'(0));
      end else begin
        check_val($sformatf("d%0d_bad_bcd", d), 32'(bcd_out), 32'(0));
        check_val($sformatf("d%0d_bad_sel", d), 32'(digit_sel), 32'(0));
        check_val($sformatf("d%0d_bad_blank", d), 32'(blank), 32'(1));
        check_val($sformatf("d%0d_bad_err", d), 32'(digit_err), 32'(1));
      end
      check_val($sformatf("d%0d_fd", d), 32'(frame_done), 32'(0));
      if (rdy_en) check_val($sformatf("d%0d_rdy", d), 32'(load_ready), 32'(exp_rdy));
      step();
    end
  endtask

  task automatic frame(input logic [15:0] w, input logic fd0,
                       input logic rdy_en, input logic exp_rdy);
    for (int d = 0; d < 4; d++) begin
      slot(w, d, (d == 0) ? fd0 : 1'b0, rdy_en, exp_rdy);
    end
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, "_blank"}, 32'(blank), 32'(1));
    check_val({tag, "_sel"}, 32'(digit_sel), 32'(0));
    check_val({tag, "_bcd"}, 32'(bcd_out), 32'(0));
    check_val({tag, "_err"}, 32'(digit_err), 32'(0));
    check_val({tag, "_fd"}, 32'(frame_done), 32'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    enable     = 1'b0;
    load_valid = 1'b0;
    load_bcd   = '0;

    step();
    check_idle("rst");
    check_val("rst_rdy", 32'(load_ready), 32'(1));
    step();
    rst_n  = 1'b1;
    enable = 1'b1;

    // Enabled with nothing loaded: must stay idle.
    for (int i = 0; i < 3; i++) begin
      step();
      check_idle("noload");
      check_val("noload_rdy", 32'(load_ready), 32'(1));
    end

    // Basic scan of 1234.
    load_valid = 1'b1;
    load_bcd   = 16'h1234;
    step();
    check_val("cap_rdy", 32'(load_ready), 32'(0));
    load_valid = 1'b0;
    step();
    check_val("start_rdy", 32'(load_ready), 32'(1));
    frame(16'h1234, 1'b0, 1'b1, 1'b1);
    frame(16'h1234, 1'b1, 1'b1, 1'b1);

    // Mid-frame load of 5678, then 9999 held against back-pressure.
    slot(16'h1234, 0, 1'b1, 1'b1, 1'b1);
    load_valid = 1'b1;
    load_bcd   = 16'h5678;
    slot(16'h1234, 1, 1'b0, 1'b0, 1'b0);
    check_val("mid_rdy", 32'(load_ready), 32'(0));
    load_bcd = 16'h9999;
    slot(16'h1234, 2, 1'b0, 1'b1, 1'b0);
    slot(16'h1234, 3, 1'b0, 1'b1, 1'b0);
    check_val("wrap_rdy", 32'(load_ready), 32'(1));
    load_valid = 1'b0;
    frame(16'h5678, 1'b1, 1'b1, 1'b1);

    // Enable drop during digit 2, then restart.
    slot(16'h5678, 0, 1'b1, 1'b1, 1'b1);
    slot(16'h5678, 1, 1'b0, 1'b1, 1'b1);
    check_val("drop_gap_blank", 32'(blank), 32'(1));
    step();
    check_val("drop_show_bcd", 32'(bcd_out), 32'(6));
    check_val("drop_show_sel", 32'(digit_sel), 32'(4'b0100));
    step();
    enable = 1'b0;
    step();
    check_idle("drop1");
    step();
    check_idle("drop2");
    enable = 1'b1;
    step();
    frame(16'h5678, 1'b0, 1'b1, 1'b1);

    // Invalid digit: load 1A34 during a 5678 frame.
    load_valid = 1'b1;
    load_bcd   = 16'h1A34;
    frame(16'h5678, 1'b1, 1'b0, 1'b0);
    load_valid = 1'b0;
    frame(16'h1A34, 1'b1, 1'b1, 1'b1);

    // Reset mid-SHOW with a load pending.
    slot(16'h1A34, 0, 1'b1, 1'b1, 1'b1);
    load_valid = 1'b1;
    load_bcd   = 16'h5678;
    step();
    load_valid = 1'b0;
    check_val("prerst_bcd", 32'(bcd_out), 32'(3));
    check_val("prerst_rdy", 32'(load_ready), 32'(0));
    rst_n = 1'b0;
    #1;
    check_idle("arst");
    check_val("arst_rdy", 32'(load_ready), 32'(1));
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check_idle("postrst");
      check_val("postrst_rdy", 32'(load_ready), 32'(1));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
